// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_CONSUMERS load/store requesters.
// Requests are serialised onto a valid/ready memory handshake. Priority rotates past each released requester.
module mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  localparam int ID_BITS      = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready,
  output logic                                     busy,
  output logic [ID_BITS-1:0]                       grant_id
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  state_t                                  state_r;
  state_t                                  next_state_s;
  logic [ID_BITS-1:0]                      rr_ptr_r;
  logic [ID_BITS-1:0]                      grant_id_r;
  logic                                    kind_read_r;
  logic                                    busy_r;
  logic [NUM_CONSUMERS-1:0]                rd_ready_r;
  logic [NUM_CONSUMERS-1:0]                wr_ready_r;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_r;
  logic                                    mem_rd_valid_r;
  logic [ADDR_BITS-1:0]                    mem_rd_addr_r;
  logic                                    mem_wr_valid_r;
  logic [ADDR_BITS-1:0]                    mem_wr_addr_r;
  logic [DATA_BITS-1:0]                    mem_wr_data_r;

  logic                                    win_found_s;
  logic [ID_BITS-1:0]                      win_id_s;
  logic                                    win_read_s;
  logic                                    held_s;
  logic                                    grant_s;
  logic                                    rd_done_s;
  logic                                    wr_done_s;
  logic                                    release_s;

  // Pick the first requester at or after rr_ptr; reads beat writes on the same requester.
  always_comb begin
    logic [ID_BITS-1:0] idx;
    win_found_s = 1'b0;
    win_id_s    = {ID_BITS{1'b0}};
    win_read_s  = 1'b0;
    idx         = {ID_BITS{1'b0}};
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = rr_ptr_r + ID_BITS'(i);
      if (!win_found_s && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
        win_found_s = 1'b1;
        win_id_s    = idx;
        win_read_s  = consumer_read_valid[idx];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // The granted requester still holds the valid of the transaction kind it was granted for.
  always_comb begin
    if (kind_read_r) begin
      held_s = consumer_read_valid[grant_id_r];
    end else begin
      held_s = consumer_write_valid[grant_id_r];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          next_state_s = win_read_s ? READ_WAIT : WRITE_WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          next_state_s = RELEASE;
        end else begin
          next_state_s = READ_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          next_state_s = RELEASE;
        end else begin
          next_state_s = WRITE_WAIT;
        end
      end
      RELEASE: begin
        if (!held_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RELEASE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Per-state action strobes driving the datapath registers.
  always_comb begin
    grant_s   = 1'b0;
    rd_done_s = 1'b0;
    wr_done_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE:       grant_s   = win_found_s;
      READ_WAIT:  rd_done_s = mem_read_ready;
      WRITE_WAIT: wr_done_s = mem_write_ready;
      RELEASE:    release_s = !held_s;
      default:    grant_s   = 1'b0;
    endcase
  end

  // Datapath and handshake output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r       <= {ID_BITS{1'b0}};
      grant_id_r     <= {ID_BITS{1'b0}};
      kind_read_r    <= 1'b0;
      rd_ready_r     <= '0;
      wr_ready_r     <= '0;
      rd_data_r      <= '0;
      mem_rd_valid_r <= 1'b0;
      mem_rd_addr_r  <= '0;
      mem_wr_valid_r <= 1'b0;
      mem_wr_addr_r  <= '0;
      mem_wr_data_r  <= '0;
    end else begin
      if (grant_s) begin
        grant_id_r  <= win_id_s;
        kind_read_r <= win_read_s;
        if (win_read_s) begin
          mem_rd_valid_r <= 1'b1;
          mem_rd_addr_r  <= consumer_read_address[win_id_s];
        end else begin
          mem_wr_valid_r <= 1'b1;
          mem_wr_addr_r  <= consumer_write_address[win_id_s];
          mem_wr_data_r  <= consumer_write_data[win_id_s];
        end
      end
      if (rd_done_s) begin
        mem_rd_valid_r         <= 1'b0;
        rd_data_r[grant_id_r]  <= mem_read_data;
        rd_ready_r[grant_id_r] <= 1'b1;
      end
      if (wr_done_s) begin
        mem_wr_valid_r         <= 1'b0;
        wr_ready_r[grant_id_r] <= 1'b1;
      end
      if (release_s) begin
        rd_ready_r <= '0;
        wr_ready_r <= '0;
        rr_ptr_r   <= grant_id_r + ID_BITS'(1);
      end
    end
  end

  assign consumer_read_ready  = rd_ready_r;
  assign consumer_read_data   = rd_data_r;
  assign consumer_write_ready = wr_ready_r;
  assign mem_read_valid       = mem_rd_valid_r;
  assign mem_read_address     = mem_rd_addr_r;
  assign mem_write_valid      = mem_wr_valid_r;
  assign mem_write_address    = mem_wr_addr_r;
  assign mem_write_data       = mem_wr_data_r;
  assign busy                 = busy_r;
  assign grant_id             = grant_id_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one external data-memory port between NUM_CONSUMERS load/store requesters (one per core thread LSU). It accepts read and write requests, serialises them onto the memory port with a valid/ready handshake, returns read data to the granted requester, and rotates priority so no requester starves. It sits between the cores started by the block dispatcher and the single global data-memory interface.

## Interface
- NUM_CONSUMERS, 4: requesters; power of two ≥2.
- ADDR_BITS, 8: memory address width.
- DATA_BITS, 8: memory data width.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low: 0 resets immediately, deassertion sampled synchronously by clk.
- consumer_read_valid  in  [NUM_CONSUMERS]  read request, held until matching ready seen.
- consumer_read_address  in  [NUM_CONSUMERS] x ADDR_BITS  read address, stable while valid.
- consumer_read_ready  out  [NUM_CONSUMERS]  read complete; data valid while high.
- consumer_read_data  out  [NUM_CONSUMERS] x DATA_BITS  returned read data, held until next read to same consumer.
- consumer_write_valid  in  [NUM_CONSUMERS]  write request.
- consumer_write_address  in  [NUM_CONSUMERS] x ADDR_BITS  write address.
- consumer_write_data  in  [NUM_CONSUMERS] x DATA_BITS  write data.
- consumer_write_ready  out  [NUM_CONSUMERS]  write complete.
- mem_read_valid  out  1; mem_read_address  out  ADDR_BITS; mem_read_ready  in  1; mem_read_data  in  DATA_BITS.
- mem_write_valid  out  1; mem_write_address  out  ADDR_BITS; mem_write_data  out  DATA_BITS; mem_write_ready  in  1.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_CONSUMERS)  currently/last granted consumer.

## Operation
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
- IDLE: scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS; first with read_valid or write_valid wins. If both set on the winner, read goes first. On grant: grant_id<=winner; for read, mem_read_valid<=1, mem_read_address<=its address, go READ_WAIT; for write, mem_write_valid<=1, latch address and data, go WRITE_WAIT. No request: stay.
- READ_WAIT: on mem_read_ready=1: mem_read_valid<=0, consumer_read_data[grant_id]<=mem_read_data, consumer_read_ready[grant_id]<=1, go RELEASE.
- WRITE_WAIT: on mem_write_ready=1: mem_write_valid<=0, consumer_write_ready[grant_id]<=1, go RELEASE.
- RELEASE: when granted consumer's corresponding valid is 0: clear its ready, rr_ptr<=grant_id+1 (wraps to 0), go IDLE. Otherwise hold ready high.
- Memory address/data outputs held stable while mem_*_valid high.
- At most one ready bit of each kind high at any time, only for grant_id.

## Timing
- Reset (reset=0): state IDLE, rr_ptr=0, grant_id=0, busy=0, all ready bits 0, all consumer_read_data 0, mem_*_valid 0, mem address/data 0. Takes effect without clock edge; in-flight transaction abandoned, no ready issued.
- Request sampled in IDLE at edge N -> mem_*_valid high after edge N.
- mem_ready high at edge M (first WAIT cycle allowed) -> consumer ready high after edge M.
- Consumer drops valid -> ready low and IDLE one edge later; next grant one edge after that. Minimum back-to-back turnaround: 4 cycles with zero-latency memory.
- Consumer dropping valid during WAIT (protocol violation): transaction still completes; RELEASE exits on first cycle, ready high exactly one cycle.
- mem_ready seen outside WAIT states: ignored.
- rr_ptr advances only on release, so a requester granted at rr_ptr position is lowest priority next round.

## Test plan
- Reset: drive reset=0 mid-READ_WAIT -> all outputs 0 immediately; after release no ready pulse for abandoned request, busy=0.
- Single read: consumer 2 reads addr 0x3C, memory returns 0xA5 with ready 2 cycles after valid -> mem_read_address=0x3C, consumer_read_ready[2]=1 with data 0xA5, grant_id=2.
- Single write: consumer 1 writes 0x7E to 0x10, memory ready immediately -> mem_write_* = 0x10/0x7E, consumer_write_ready[1] pulse, memory written once.
- Round-robin: all 4 consumers request reads continuously from reset -> grant order 0,1,2,3,0; none granted twice before others served.
- Read+write same consumer: consumer 3 asserts both -> read serviced first, then write on a later grant (after other pending requesters per rr_ptr).
- Early valid drop: consumer 0 drops read_valid during READ_WAIT -> on mem_read_ready, consumer_read_ready[0] high exactly one cycle, FSM returns IDLE.
